serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Parallel-in, serial-out frame transmitter: the sending end of the team's serial-in shift/ring receiver tiles.
//  A 4-bit nibble on the input pins is framed and shifted out LSB-first: start(0), data, even parity, stop(1).
//  A 1-entry holding buffer allows back-to-back frames. Sits as a TinyTapeout user tile on the 8-in/8-out pin bus.
// PARAMETERS
//  DATA_W     4   data bits per frame; fixed by pin budget (io_in[5:2], io_out[7:4])
//  BIT_DIV    1   clocks per serial bit, >=1
//  PARITY_EN  1   1: even-parity bit after data; 0: parity state skipped
// PORTS
//  io_in[0]    in   1  clk, single clock; all logic on its rising edge
//  io_in[1]    in   1  reset, synchronous, active-high
//  io_in[5:2]  in   4  data nibble, sampled when a send edge is accepted
//  io_in[6]    in   1  send; rising edge (0 then 1 on consecutive clocks) requests one frame
//  io_in[7]    in   1  hold; 1 freezes the bit timer and FSM, txd keeps its value
//  io_out[0]   out  1  txd serial line, idles high
//  io_out[1]   out  1  busy, 1 whenever FSM != IDLE
//  io_out[2]   out  1  buf_full, holding buffer occupied
//  io_out[3]   out  1  overflow, sticky; a send edge arrived with shifter busy and buffer full
//  io_out[7:4] out  4  last_sent, nibble of the most recently completed frame
// BEHAVIOUR
//  Reset: txd=1, busy=0, buf_full=0, overflow=0, last_sent=0, FSM=IDLE, timer=0, send_q=1.
//   send_q resets to 1, so send held high through reset gives no request.
//  Reset mid-frame aborts: txd=1 on the next clock, buffered nibble discarded.
//  Edge detect: send_edge = io_in[6] & ~send_q; send_q <= io_in[6] every clock, including under hold.
//  Accept on send_edge:
//   - IDLE, buffer empty, hold=0: load shifter, FSM->START; txd=0 in the next cycle (1-clock latency).
//   - Otherwise, buffer empty: nibble -> buffer, buf_full=1.
//   - Buffer full: request dropped, overflow<=1.
//  FSM: IDLE -> START -> DATA (DATA_W bits) -> PARITY (if PARITY_EN) -> STOP -> IDLE|START.
//   - Each state lasts BIT_DIV clocks. Bit timer counts 0..BIT_DIV-1; bit index counts 0..DATA_W-1.
//   - txd is registered: START=0, DATA=shifter[0] (shift right per bit), PARITY=^nibble, STOP=1.
//   - Frame length (1+DATA_W+PARITY_EN+1)*BIT_DIV clocks; 7 at defaults.
//  Leaving STOP:
//   - last_sent<=nibble.
//   - If buf_full, or a send_edge in that same cycle: go directly to START with the new nibble.
//     No idle bit between frames. buf_full clears the same cycle.
//   - Else IDLE.
//  IDLE with buf_full and hold=0: FSM->START next clock; buffer is drained first, before any new edge.
//  Simultaneous drain + new edge: the buffered nibble goes to the shifter; the new nibble goes to the buffer.
//  hold=1: timer, bit index, FSM and txd frozen; edges are still accepted into the buffer; overflow still sets.
//  Width rules: timer is clog2(BIT_DIV) bits with a minimum of 1; wraps only by explicit compare-to-(BIT_DIV-1); no arithmetic overflow.
// STRUCTURE
//  Package serial_frame_pkg: FSM state encoding (IDLE/START/DATA/PARITY/STOP, 3 bits),
//   DATA_W, frame-length constant, and the pin-index localparams shared with the receiver tile.
//  Sub-module serial_bit_timer: BIT_DIV divider with hold input; outputs one-cycle bit_tick.
//  Top: edge detect, holding buffer, shifter, FSM, output registers.
// TESTING
//  1 Reset, send edge with data=4'b1011 -> txd = 0,1,1,0,1,1(parity),1 over 7 clocks; busy high 7 clocks; last_sent=4'hB after.
//  2 Send 4'h3 then 4'hC two clocks later -> buf_full=1; second frame's start bit immediately follows the first frame's stop; overflow=0.
//  3 Third edge while busy and buf_full -> overflow=1 and stays 1; dropped nibble never appears on txd.
//  4 hold=1 for 5 clocks mid-DATA -> txd constant for 5 clocks; frame stretches to 12 clocks; bit values unchanged.
//  5 reset asserted in DATA -> next cycle txd=1, busy=0, buf_full=0; send held high across reset produces no frame.
//  6 BIT_DIV=3, PARITY_EN=0, data 4'h5 -> each bit 3 clocks wide, 18-clock frame, no parity bit.

Source files
------------

// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_pkg
// Purpose  : Shared constants, pin map and FSM encoding for the serial frame
//            transmitter tile and its matching receiver tile.
// Revision : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

    // Data bits per frame; fixed by the nibble-wide pin budget
    localparam int c_DATA_W    = 4;
    localparam int c_IDX_W     = $clog2(c_DATA_W);
    // Frame length in bit periods with parity enabled: start + data + parity + stop
    localparam int c_FRAME_LEN = 1 + c_DATA_W + 1 + 1;

    // Input pin map of the 8-bit tile bus
    localparam int c_PIN_CLK     = 0;
    localparam int c_PIN_RST     = 1;
    localparam int c_PIN_DATA_LO = 2;
    localparam int c_PIN_SEND    = 6;
    localparam int c_PIN_HOLD    = 7;

    // Output pin map of the 8-bit tile bus
    localparam int c_POUT_TXD     = 0;
    localparam int c_POUT_BUSY    = 1;
    localparam int c_POUT_BUFFULL = 2;
    localparam int c_POUT_OVF     = 3;
    localparam int c_POUT_LAST_LO = 4;

    // Transmitter FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_timer
// Purpose  : Divides the clock by BIT_DIV while running; emits a one-cycle
//            bit_tick at the last clock of each bit period. Hold freezes it.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_timer #(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_hold,
    output logic o_bit_tick
);

    // Counter is at least one bit wide so BIT_DIV=1 still elaborates cleanly
    localparam int                 c_CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIT_DIV - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               at_last;

    assign at_last    = (cnt_q == c_LAST);
    assign o_bit_tick = i_run & ~i_hold & at_last;

    // Next count: parked at zero while idle, frozen on hold, explicit wrap at the last clock
    always_comb begin
        cnt_d = cnt_q;
        if (!i_run) begin
            cnt_d = '0;
        end else if (!i_hold) begin
            if (at_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Purpose  : Nibble-parallel-in, serial-out frame transmitter tile. Frames
//            are start(0), data LSB-first, optional even parity, stop(1),
//            with a one-entry holding buffer for back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int BIT_DIV   = 1,
    parameter int PARITY_EN = 1
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_DATA_W - 1);

    logic                clk;
    logic                rst;
    logic                send_in;
    logic                hold;
    logic [c_DATA_W-1:0] data_in;

    assign clk     = io_in[c_PIN_CLK];
    assign rst     = io_in[c_PIN_RST];
    assign send_in = io_in[c_PIN_SEND];
    assign hold    = io_in[c_PIN_HOLD];
    assign data_in = io_in[c_PIN_DATA_LO +: c_DATA_W];

    tx_state_t           state_q,     state_d;
    logic [c_DATA_W-1:0] shift_q,     shift_d;
    logic [c_DATA_W-1:0] nibble_q,    nibble_d;
    logic [c_IDX_W-1:0]  idx_q,       idx_d;
    logic                txd_q,       txd_d;
    logic [c_DATA_W-1:0] buf_q,       buf_d;
    logic                buf_full_q,  buf_full_d;
    logic                overflow_q,  overflow_d;
    logic [c_DATA_W-1:0] last_sent_q, last_sent_d;
    logic                send_q;

    logic                busy;
    logic                bit_tick;
    logic                send_edge;
    logic                start_ok;
    logic                launch;
    logic [c_DATA_W-1:0] launch_nib;

    assign busy      = (state_q != ST_IDLE);
    assign send_edge = send_in & ~send_q;
    // A new frame may begin from idle (unless held) or straight out of a finishing stop bit
    assign start_ok  = ((state_q == ST_IDLE) && !hold) || ((state_q == ST_STOP) && bit_tick);

    serial_bit_timer #(
        .BIT_DIV    (BIT_DIV)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .i_run      (busy),
        .i_hold     (hold),
        .o_bit_tick (bit_tick)
    );

    // Request arbitration, buffer handling and FSM next-state / next-txd
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        nibble_d    = nibble_q;
        idx_d       = idx_q;
        txd_d       = txd_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        overflow_d  = overflow_q;
        last_sent_d = last_sent_q;
        launch      = 1'b0;
        launch_nib  = buf_q;

        // Buffered nibble always drains before a fresh edge; the fresh edge refills the buffer
        if (start_ok) begin
            if (buf_full_q) begin
                launch     = 1'b1;
                launch_nib = buf_q;
                buf_full_d = send_edge;
                if (send_edge) begin
                    buf_d = data_in;
                end
            end else if (send_edge) begin
                launch     = 1'b1;
                launch_nib = data_in;
            end
        end else if (send_edge) begin
            if (!buf_full_q) begin
                buf_d      = data_in;
                buf_full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        // txd is loaded together with the state so it always reflects the current bit
        if (bit_tick) begin
            unique case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
                ST_DATA: begin
                    if (idx_q == c_LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            txd_d   = ^nibble_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
                ST_STOP: begin
                    state_d     = ST_IDLE;
                    txd_d       = 1'b1;
                    last_sent_d = nibble_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end

        // Launching overrides the stop->idle step so frames abut with no idle bit
        if (launch) begin
            state_d  = ST_START;
            txd_d    = 1'b0;
            shift_d  = launch_nib;
            nibble_d = launch_nib;
        end
    end

    // State and output registers; send_q resets high so a send held through reset is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            nibble_q    <= '0;
            idx_q       <= '0;
            txd_q       <= 1'b1;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            overflow_q  <= 1'b0;
            last_sent_q <= '0;
            send_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            nibble_q    <= nibble_d;
            idx_q       <= idx_d;
            txd_q       <= txd_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            overflow_q  <= overflow_d;
            last_sent_q <= last_sent_d;
            send_q      <= send_in;
        end
    end

    // Pack status onto the output pin bus
    always_comb begin
        io_out                                = '0;
        io_out[c_POUT_TXD]                    = txd_q;
        io_out[c_POUT_BUSY]                   = busy;
        io_out[c_POUT_BUFFULL]                = buf_full_q;
        io_out[c_POUT_OVF]                    = overflow_q;
        io_out[c_POUT_LAST_LO +: c_DATA_W]    = last_sent_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx
// Purpose  : Directed self-checking bench for serial_frame_tx. One instance
//            at default parameters, one at BIT_DIV=3 / no parity.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       r_rst;
    logic [3:0] r_data;
    logic       r_send_a;
    logic       r_send_b;
    logic       r_hold;

    logic [7:0] w_in_a;
    logic [7:0] w_in_b;
    logic [7:0] w_out_a;
    logic [7:0] w_out_b;

    int n_cmp = 0;
    int n_err = 0;

    assign w_in_a = {r_hold, r_send_a, r_data, r_rst, clk};
    assign w_in_b = {1'b0,   r_send_b, r_data, r_rst, clk};

    serial_frame_tx #(.BIT_DIV(1), .PARITY_EN(1)) u_dut_a (
        .io_in  (w_in_a),
        .io_out (w_out_a)
    );

    serial_frame_tx #(.BIT_DIV(3), .PARITY_EN(0)) u_dut_b (
        .io_in  (w_in_b),
        .io_out (w_out_b)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One send edge on the selected instance; returns just after the accepting clock edge
    task automatic pulse_send(input logic sel_b, input logic [3:0] nib);
        @(posedge clk);
        #1;
        r_data = nib;
        if (sel_b) r_send_b = 1'b1; else r_send_a = 1'b1;
        @(posedge clk);
        #1;
        if (sel_b) r_send_b = 1'b0; else r_send_a = 1'b0;
    endtask

    // Check txd of instance A over n consecutive cycles; pattern bit 0 is the first cycle
    task automatic expect_txd(input string tag, input logic [63:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val(tag, {31'd0, w_out_a[0]}, {31'd0, pat[i]});
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        r_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r_rst = 1'b0;
    endtask

    // Hard time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_rst    = 1'b1;
        r_data   = 4'h0;
        r_send_a = 1'b1;
        r_send_b = 1'b1;
        r_hold   = 1'b0;

        // ---- reset state, send held high through reset ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_txd",      {31'd0, w_out_a[0]}, 32'd1);
        check_val("rst_busy",     {31'd0, w_out_a[1]}, 32'd0);
        check_val("rst_buf_full", {31'd0, w_out_a[2]}, 32'd0);
        check_val("rst_overflow", {31'd0, w_out_a[3]}, 32'd0);
        check_val("rst_last",     {28'd0, w_out_a[7:4]}, 32'd0);
        check_val("rst_b_txd",    {31'd0, w_out_b[0]}, 32'd1);
        @(posedge clk);
        #1;
        r_rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_val("rst_held_send_busy", {31'd0, w_out_a[1]}, 32'd0);
            check_val("rst_held_send_txd",  {31'd0, w_out_a[0]}, 32'd1);
        end
        r_send_a = 1'b0;
        r_send_b = 1'b0;

        // ---- test 1: single frame 4'hB ----
        pulse_send(1'b0, 4'hB);
        for (int i = 0; i < 7; i++) begin
            logic [6:0] pat1;
            pat1 = 7'b1110110;
            @(negedge clk);
            check_val("t1_txd",  {31'd0, w_out_a[0]}, {31'd0, pat1[i]});
            check_val("t1_busy", {31'd0, w_out_a[1]}, 32'd1);
        end
        @(negedge clk);
        check_val("t1_busy_end", {31'd0, w_out_a[1]}, 32'd0);
        check_val("t1_txd_idle", {31'd0, w_out_a[0]}, 32'd1);
        check_val("t1_last",     {28'd0, w_out_a[7:4]}, 32'hB);

        // ---- test 2: back-to-back 4'h3 then 4'hC via the buffer ----
        pulse_send(1'b0, 4'h3);
        pulse_send(1'b0, 4'hC);
        expect_txd("t2_f1_txd", 64'b10001, 5);
        check_val("t2_buf_full", {31'd0, w_out_a[2]}, 32'd1);
        expect_txd("t2_f2_start", 64'b0, 1);
        check_val("t2_buf_drained", {31'd0, w_out_a[2]}, 32'd0);
        check_val("t2_busy_gap",    {31'd0, w_out_a[1]}, 32'd1);
        check_val("t2_last_f1",     {28'd0, w_out_a[7:4]}, 32'h3);
        expect_txd("t2_f2_txd", 64'b101100, 6);
        @(negedge clk);
        check_val("t2_busy_end", {31'd0, w_out_a[1]}, 32'd0);
        check_val("t2_last",     {28'd0, w_out_a[7:4]}, 32'hC);
        check_val("t2_overflow", {31'd0, w_out_a[3]}, 32'd0);

        // ---- test 3: third edge while busy and buffer full ----
        pulse_send(1'b0, 4'h5);
        pulse_send(1'b0, 4'h6);
        pulse_send(1'b0, 4'h9);
        check_val("t3_overflow_set", {31'd0, w_out_a[3]}, 32'd1);
        check_val("t3_buf_full",     {31'd0, w_out_a[2]}, 32'd1);
        expect_txd("t3_txd", 64'b1001100100, 10);
        @(negedge clk);
        check_val("t3_busy_end", {31'd0, w_out_a[1]}, 32'd0);
        check_val("t3_last",     {28'd0, w_out_a[7:4]}, 32'h6);
        repeat (3) begin
            @(negedge clk);
            check_val("t3_no_dropped_frame", {31'd0, w_out_a[1]}, 32'd0);
            check_val("t3_overflow_sticky",  {31'd0, w_out_a[3]}, 32'd1);
        end

        // ---- test 4: hold for 5 clocks mid-DATA ----
        do_reset();
        @(negedge clk);
        check_val("t4_overflow_cleared", {31'd0, w_out_a[3]}, 32'd0);
        pulse_send(1'b0, 4'hB);
        expect_txd("t4_pre_hold", 64'b10, 2);
        r_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t4_hold_txd",  {31'd0, w_out_a[0]}, 32'd1);
            check_val("t4_hold_busy", {31'd0, w_out_a[1]}, 32'd1);
        end
        r_hold = 1'b0;
        expect_txd("t4_post_hold", 64'b11101, 5);
        @(negedge clk);
        check_val("t4_busy_end", {31'd0, w_out_a[1]}, 32'd0);
        check_val("t4_last",     {28'd0, w_out_a[7:4]}, 32'hB);

        // ---- test 5: reset mid-frame, send held high across reset ----
        @(posedge clk);
        #1;
        r_data   = 4'h9;
        r_send_a = 1'b1;
        @(posedge clk);
        #1;
        r_send_a = 1'b0;
        @(posedge clk);
        #1;
        r_data   = 4'h6;
        r_send_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("t5_pre_buf_full", {31'd0, w_out_a[2]}, 32'd1);
        check_val("t5_pre_busy",     {31'd0, w_out_a[1]}, 32'd1);
        r_rst = 1'b1;
        @(negedge clk);
        check_val("t5_abort_txd",      {31'd0, w_out_a[0]}, 32'd1);
        check_val("t5_abort_busy",     {31'd0, w_out_a[1]}, 32'd0);
        check_val("t5_abort_buf_full", {31'd0, w_out_a[2]}, 32'd0);
        r_rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_val("t5_no_frame_busy", {31'd0, w_out_a[1]}, 32'd0);
            check_val("t5_no_frame_txd",  {31'd0, w_out_a[0]}, 32'd1);
        end
        r_send_a = 1'b0;

        // ---- test 6: BIT_DIV=3, no parity, data 4'h5 ----
        pulse_send(1'b1, 4'h5);
        for (int k = 0; k < 18; k++) begin
            logic [5:0] pat6;
            pat6 = 6'b101010;
            @(negedge clk);
            check_val("t6_txd",  {31'd0, w_out_b[0]}, {31'd0, pat6[k / 3]});
            check_val("t6_busy", {31'd0, w_out_b[1]}, 32'd1);
        end
        @(negedge clk);
        check_val("t6_busy_end", {31'd0, w_out_b[1]}, 32'd0);
        check_val("t6_txd_idle", {31'd0, w_out_b[0]}, 32'd1);
        check_val("t6_last",     {28'd0, w_out_b[7:4]}, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
